// File: rtl/popcount_pkg.sv
// Shared types and sizing helpers for the sequential population counter.
// Used by popcount_chunk and popcount_seq.

package popcount_pkg;

  // Controller states: waiting for a word, counting chunks, presenting a result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } pc_state_t;

  // Bits needed to hold a count of 0..n ones.
  function automatic int count_width(input int n);
    return $clog2(n + 1);
  endfunction

  // Bits needed to index n chunks.
  // One chunk still needs a 1-bit index register.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : popcount_pkg

// File: rtl/popcount_chunk.sv
// Combinational ones counter for one CHUNK-bit slice of the word.
// The result is $clog2(CHUNK+1) bits wide, so an all-ones chunk fits.

module popcount_chunk
  import popcount_pkg::*;
#(
  parameter  int CHUNK = 4,
  localparam int CNT_W = count_width(CHUNK)
) (
  input  logic [CHUNK-1:0] data_i,
  output logic [CNT_W-1:0] count_o
);

  // Sum the individual bits of the slice.
  always_comb begin
    // NOTE: assigning a default before the loop keeps this purely combinational (no latch).
    count_o = '0;
    for (int i = 0; i < CHUNK; i++) begin
      count_o = count_o + CNT_W'(data_i[i]);
    end
  end

endmodule : popcount_chunk

// File: rtl/popcount_seq.sv
// Multi-cycle population counter with valid/ready on both sides.
// A word is captured on accept, then counted CHUNK bits per cycle from the
// low end of a shift register. After NCHUNK cycles the count is presented
// and held until the consumer takes it.
// Optional feature: define POPCOUNT_PARITY_EN to add out_parity, which is
// the XOR of the accepted word (the LSB of the count).

module popcount_seq
  import popcount_pkg::*;
#(
  parameter  int WIDTH   = 32,
  parameter  int CHUNK   = 4,
  localparam int COUNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  output logic               out_valid,
  input  logic               out_ready,
`ifdef POPCOUNT_PARITY_EN
  output logic               out_parity,
`endif
  output logic [COUNT_W-1:0] out_count
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CNT_W  = count_width(CHUNK);
  localparam int IDX_W  = idx_width(NCHUNK);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  // Reject configurations that cannot split the word into whole chunks.
  if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
    $error("popcount_seq: WIDTH (%0d) must be a non-zero multiple of CHUNK (%0d)",
           WIDTH, CHUNK);
  end

  pc_state_t            state_q, state_d;
  logic [WIDTH-1:0]     shreg_q, shreg_d;
  logic [IDX_W-1:0]     idx_q,   idx_d;
  logic [COUNT_W-1:0]   acc_q,   acc_d;
  logic [CNT_W-1:0]     chunk_ones;

  // The low chunk of the shift register is the slice counted this cycle.
  popcount_chunk #(
    .CHUNK (CHUNK)
  ) u_chunk (
    .data_i  (shreg_q[CHUNK-1:0]),
    .count_o (chunk_ones)
  );

  // Next-state, datapath updates and handshake outputs.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    idx_d     = idx_q;
    acc_d     = acc_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          shreg_d = in_data;
          acc_d   = '0;
          idx_d   = '0;
          state_d = BUSY;
        end
      end

      BUSY: begin
        // The per-chunk sum is zero-extended; acc cannot exceed WIDTH.
        acc_d   = acc_q + COUNT_W'(chunk_ones);
        shreg_d = shreg_q >> CHUNK;
        idx_d   = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = DONE;
        end
      end

      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort wins over any accept or output handshake in the same cycle.
    if (clear) begin
      state_d = IDLE;
      shreg_d = '0;
      idx_d   = '0;
      acc_d   = '0;
    end
  end

  // State and datapath registers.
  // NOTE: reset is asynchronous so a word in flight is dropped at once, not at the next edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      idx_q   <= '0;
      acc_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      state_q <= state_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
    end
  end

  // The accumulator is the result; it only changes in BUSY, so it is held in DONE.
  assign out_count = acc_q;

`ifdef POPCOUNT_PARITY_EN
  // The XOR of the word equals the LSB of its ones count.
  assign out_parity = acc_q[0];
`endif

endmodule : popcount_seq

// File: tb/tb_popcount_seq.sv
// Self-checking bench for popcount_seq (WIDTH=32, CHUNK=4).
// Directed words with hand-computed counts are pushed to a scoreboard queue
// when issued; a monitor pops and compares on every output handshake.
// Build with POPCOUNT_PARITY_EN defined to also check out_parity.

module tb_popcount_seq;

  localparam int WIDTH   = 32;
  localparam int CHUNK   = 4;
  localparam int NCHUNK  = 8;
  localparam int COUNT_W = 6;

  logic               clk = 1'b0;
  logic               rst;
  logic               clear;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic               out_valid;
  logic               out_ready;
  logic [COUNT_W-1:0] out_count;
`ifdef POPCOUNT_PARITY_EN
  logic               out_parity;
`endif

  typedef struct {
    logic [WIDTH-1:0]   word;
    logic [COUNT_W-1:0] count;
    logic               parity;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  int tests_run    = 0;
  int tests_failed = 0;

  popcount_seq #(
    .WIDTH (WIDTH),
    .CHUNK (CHUNK)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
`ifdef POPCOUNT_PARITY_EN
    .out_parity (out_parity),
`endif
    .out_count  (out_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every output handshake must match the oldest expected result.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL unexpected_output: got count %0d, expected no output", out_count);
      end else begin
        mon_e = exp_q.pop_front();
        check($sformatf("count_%08h", mon_e.word), 32'(out_count), 32'(mon_e.count));
`ifdef POPCOUNT_PARITY_EN
        check($sformatf("parity_%08h", mon_e.word), 32'(out_parity), 32'(mon_e.parity));
`endif
      end
    end
  end

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one word and hold it until accepted; optionally record the expected result.
  task automatic accept(input logic [WIDTH-1:0] w, input logic [COUNT_W-1:0] cnt,
                        input logic par, input bit push);
    exp_t x;
    int   n;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    check("in_ready_before_accept", 32'(in_ready), 32'd1);
    in_data  = w;
    in_valid = 1'b1;
    if (push) begin
      x.word   = w;
      x.count  = cnt;
      x.parity = par;
      exp_q.push_back(x);
    end
    tick();
    in_valid = 1'b0;
    in_data  = $urandom();
    check("busy_in_ready", 32'(in_ready), 32'd0);
  endtask

  // Count edges from accept until out_valid rises (bounded).
  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
      // Scramble input data while busy; it must be ignored.
      in_data = $urandom();
    end while (!out_valid && lat < 40);
  endtask

  task automatic run_word(input logic [WIDTH-1:0] w, input logic [COUNT_W-1:0] cnt,
                          input logic par);
    int lat;
    out_ready = 1'b1;
    accept(w, cnt, par, 1'b1);
    wait_valid(lat);
    check($sformatf("latency_%08h", w), 32'(lat), 32'(NCHUNK));
    tick();
    check($sformatf("pulse_%08h", w), 32'(out_valid), 32'd0);
  endtask

  // Safety net in case a handshake never completes.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    int seen;
    rst       = 1'b1;
    clear     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;

    // Reset values.
    #2;
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_count", 32'(out_count), 32'd0);
`ifdef POPCOUNT_PARITY_EN
    check("rst_out_parity", 32'(out_parity), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("idle_in_ready",  32'(in_ready),  32'd1);
    check("idle_out_valid", 32'(out_valid), 32'd0);

    // Basic function and boundaries.
    run_word(32'h0000000F, 6'd4,  1'b0);
    run_word(32'hFFFFFFFF, 6'd32, 1'b0);
    run_word(32'h00000000, 6'd0,  1'b0);
    run_word(32'h80000001, 6'd2,  1'b0);
    run_word(32'h12345678, 6'd13, 1'b1);
    run_word(32'h00000007, 6'd3,  1'b1);

    // Backpressure: result held for 5 stalled cycles, new word ignored.
    out_ready = 1'b0;
    accept(32'hA5A5A5A5, 6'd16, 1'b0, 1'b1);
    wait_valid(lat);
    check("latency_stall", 32'(lat), 32'(NCHUNK));
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 32'hFFFFFFFF;
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_out_count", 32'(out_count), 32'd16);
      check("stall_in_ready",  32'(in_ready),  32'd0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("stall_release_valid", 32'(out_valid), 32'd0);
    check("stall_release_ready", 32'(in_ready),  32'd1);

    // clear on the third BUSY cycle: back to IDLE, no result.
    accept(32'hFFFF0000, 6'd16, 1'b0, 1'b0);
    tick();
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clear_busy_in_ready",  32'(in_ready),  32'd1);
    check("clear_busy_out_valid", 32'(out_valid), 32'd0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid) seen++;
    end
    check("clear_busy_no_output", 32'(seen), 32'd0);

    // clear beats a simultaneous accept.
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'hFFFFFFFF;
    tick();
    clear    = 1'b0;
    in_valid = 1'b0;
    check("clear_accept_in_ready", 32'(in_ready), 32'd1);
    tick();
    check("clear_accept_out_valid", 32'(out_valid), 32'd0);

    // clear while DONE drops out_valid and zeroes the accumulator.
    out_ready = 1'b0;
    accept(32'h00000003, 6'd2, 1'b0, 1'b0);
    wait_valid(lat);
    check("latency_clear_done", 32'(lat), 32'(NCHUNK));
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clear_done_out_valid", 32'(out_valid), 32'd0);
    check("clear_done_in_ready",  32'(in_ready),  32'd1);
    check("clear_done_out_count", 32'(out_count), 32'd0);
    out_ready = 1'b1;

    // Asynchronous reset mid-BUSY takes effect without a clock edge.
    accept(32'hFFFFFFFF, 6'd32, 1'b0, 1'b0);
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_in_ready",  32'(in_ready),  32'd1);
    check("async_rst_out_valid", 32'(out_valid), 32'd0);
    check("async_rst_out_count", 32'(out_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Recovery after reset.
    run_word(32'h0000FFFF, 6'd16, 1'b0);

    tick();
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_popcount_seq
